mat_mult_stream_ctrl: RTL and testbench
=======================================

Name: mat_mult_stream_ctrl

Overview:
Stream front-end for the 4x4 8-bit matrix-multiply accelerator.
- Accepts operand words on a 32-bit valid/ready input stream and assembles them into mat_A and mat_B.
- Holds the operands stable for the multiplier latency, then captures mat_C into a result buffer.
- Drains the result buffer as 32-bit words on a valid/ready output stream.
- Sits between the accelerator's bus/DMA adapter and the multiplier core.

Parameters:
MULT_LATENCY, 1, clock edges from stable operands to updated mat_C_i (legal range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid_i  input  1  operand word valid
in_ready_o  output  1  operand word accepted when in_valid_i & in_ready_o
in_data_i  input  32  operand word
mat_A_o  output  16x8  operand A to multiplier, element i = row i/4, column i%4
mat_B_o  output  16x8  operand B to multiplier, same layout
mat_C_i  input  16x16  result from multiplier, same layout
out_valid_o  output  1  result word valid
out_ready_i  input  1  result word consumed when out_valid_o & out_ready_i
out_data_o  output  32  result word
out_last_o  output  1  high with the 8th result word of a matrix
busy_o  output  1  high while any operand load, compute or drain is in progress

Behaviour:
- Reset values (asynchronous): mat_A_o = 0, mat_B_o = 0, result buffer = 0, word counters = 0, in FSM = IN_LOAD, buf_full = 0. Consequently out_valid_o = 0, out_last_o = 0, out_data_o = 0, busy_o = 0, in_ready_o = 1.
- Input packing: 8 words per matrix pair, counter in_cnt 0..7.
  - Words 0..3 load mat_A_o[4k+b] = in_data_i[8b+7:8b] for b = 0..3 (little-endian bytes).
  - Words 4..7 load mat_B_o the same way, with k = in_cnt-4.
- Input FSM:
  - IN_LOAD: in_ready_o = 1. Each handshake writes 4 bytes and increments in_cnt. On the handshake of word 7: in_cnt -> 0, wait counter <= MULT_LATENCY, go to IN_WAIT.
  - IN_WAIT: in_ready_o = 0. Wait counter decrements each edge. When it reaches 0, go to IN_HOLD.
  - IN_HOLD: in_ready_o = 0. Capture is allowed when buf_full = 0, or when the output-side last-word handshake occurs on the same edge. On capture: result buffer <= mat_C_i, buf_full <= 1, out_cnt <= 0, go to IN_LOAD.
  - Capture check is combinational in IN_HOLD, so the earliest capture is at edge E+MULT_LATENCY+1, where E is the word-7 handshake edge.
- Operands are never modified outside IN_LOAD. mat_A_o/mat_B_o stay constant from edge E until the next load handshake.
- A new operand load may overlap the drain of the previous result; the result buffer is independent of the operands.
- Output side:
  - out_valid_o = buf_full.
  - out_data_o = {buf[2*out_cnt+1], buf[2*out_cnt]}.
  - out_last_o = buf_full & (out_cnt == 7).
  - Each handshake increments out_cnt. On the last handshake without a simultaneous capture, buf_full <= 0 and out_cnt <= 0.
  - With a simultaneous capture, buf_full stays 1, out_cnt <= 0 and new data is presented on the next cycle, so there is no valid gap.
  - out_data_o/out_last_o must hold stable while out_valid_o & !out_ready_i.
- Widths: mat_C elements pass through unmodified; the block performs no arithmetic on results.
- busy_o = (in FSM != IN_LOAD) | (in_cnt != 0) | buf_full.
- Reset asserted mid-load or mid-drain: all state returns to reset values immediately. The partial matrix and the buffered result are discarded; no output word is replayed.

Test Plan:
- Identity: A words 0x00000001, 0x00000100, 0x00010000, 0x01000000; B words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; out_ready_i = 1 -> output words 0x00020001, 0x00040003, ..., 0x0010000F, out_last_o only on the 8th, busy_o low afterwards.
- Latency (MULT_LATENCY = 3, stub multiplier with 3-edge latency): word-7 handshake at edge E -> in_ready_o low for edges E+1..E+4, capture at E+4, out_valid_o high in the cycle after E+4; the captured value equals the stub's post-update output.
- Backpressure: out_ready_i toggling 1-0-0-1 pseudo-randomly -> out_data_o stable while stalled, exactly 8 words, order preserved, no duplicates.
- Overlap: load pair 2 during the drain of pair 1, with pair-1 word 7 consumed on the same edge as the pair-2 capture -> out_valid_o continuously high, 16 words, out_last_o on words 8 and 16.
- Saturation: all operand bytes 0xFF with the real multiplier -> every output word 0xF804F804 (16-bit truncation from the multiplier preserved).
- Reset mid-operation: rst_n low after input word 5, and separately after output word 3 -> all outputs at reset values while low; a subsequent full load produces correct results with no stale data.

Source files
------------

// File: rtl/mat_mult_stream_ctrl.sv
// mat_mult_stream_ctrl: stream front-end for the 4x4 8-bit matrix multiplier.
// Packs 8 input words into mat_A/mat_B, waits out the multiplier, buffers mat_C, drains 8 words.
//   clk, rst_n             : clock, async active-low reset
//   in_valid_i/in_ready_o  : operand word handshake, in_data_i = 4 little-endian bytes
//   mat_A_o, mat_B_o       : operands, element i = row i/4, col i%4
//   mat_C_i                : multiplier result, same layout, 16-bit elements
//   out_valid_o/out_ready_i: result word handshake, out_data_o = 2 elements, out_last_o on 8th
//   busy_o                 : load, compute or drain in progress
module mat_mult_stream_ctrl #(
  parameter int unsigned MULT_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_data_i,
  output logic [15:0][7:0]  mat_A_o,
  output logic [15:0][7:0]  mat_B_o,
  input  logic [15:0][15:0] mat_C_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic              out_last_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IN_LOAD,
    IN_WAIT,
    IN_HOLD
  } in_st_t;

  localparam logic [3:0] LAT = 4'(MULT_LATENCY);

  in_st_t             st;
  logic [2:0]         in_cnt;
  logic [3:0]         wait_cnt;
  logic [15:0][15:0]  rbuf;
  logic               buf_full;
  logic [2:0]         out_cnt;

  logic in_hs;
  logic out_hs;
  logic last_hs;
  logic cap;

  assign in_hs   = in_valid_i & in_ready_o;
  assign out_hs  = buf_full & out_ready_i;
  assign last_hs = out_hs & (out_cnt == 3'd7);
  // Capture may reuse the buffer on the very edge its last word leaves.
  assign cap     = (st == IN_HOLD) & (~buf_full | last_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IN_LOAD;
      in_cnt     <= 3'd0;
      wait_cnt   <= 4'd0;
      in_ready_o <= 1'b1;
      mat_A_o    <= '0;
      mat_B_o    <= '0;
    end else begin
      unique case (st)
        IN_LOAD: begin
          if (in_hs) begin
            for (int b = 0; b < 4; b++) begin
              if (!in_cnt[2])
                mat_A_o[{in_cnt[1:0], 2'(b)}] <= in_data_i[8*b +: 8];
              else
                mat_B_o[{in_cnt[1:0], 2'(b)}] <= in_data_i[8*b +: 8];
            end
            if (in_cnt == 3'd7) begin
              in_cnt     <= 3'd0;
              wait_cnt   <= LAT;
              st         <= IN_WAIT;
              in_ready_o <= 1'b0;
            end else begin
              in_cnt <= in_cnt + 3'd1;
            end
          end
        end
        IN_WAIT: begin
          // Leave on the edge the counter reaches zero.
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            st       <= IN_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        IN_HOLD: begin
          if (cap) begin
            st         <= IN_LOAD;
            in_ready_o <= 1'b1;
          end
        end
        default: begin
          st         <= IN_LOAD;
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf     <= '0;
      buf_full <= 1'b0;
      out_cnt  <= 3'd0;
    end else if (cap) begin
      rbuf     <= mat_C_i;
      buf_full <= 1'b1;
      out_cnt  <= 3'd0;
    end else if (out_hs) begin
      if (out_cnt == 3'd7) begin
        buf_full <= 1'b0;
        out_cnt  <= 3'd0;
      end else begin
        out_cnt <= out_cnt + 3'd1;
      end
    end
  end

  assign out_valid_o = buf_full;
  assign out_data_o  = {rbuf[{out_cnt, 1'b1}], rbuf[{out_cnt, 1'b0}]};
  assign out_last_o  = buf_full & (out_cnt == 3'd7);
  assign busy_o      = (st != IN_LOAD) | (in_cnt != 3'd0) | buf_full;

endmodule

// File: tb/tb_mat_mult_stream_ctrl.sv
// tb_mat_mult_stream_ctrl: directed bench for mat_mult_stream_ctrl.
// Stub multiplier with 3-edge latency feeds mat_C_i.
module tb_mat_mult_stream_ctrl;

  localparam int LAT = 3;

  typedef logic [15:0][15:0] cmat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic [15:0][7:0]  mat_a;
  logic [15:0][7:0]  mat_b;
  cmat_t             mat_c;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_data;
  logic              out_last;
  logic              busy;

  int total = 0;
  int bad = 0;

  logic [31:0] ops[8];
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  mat_mult_stream_ctrl #(.MULT_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .mat_A_o    (mat_a),
    .mat_B_o    (mat_b),
    .mat_C_i    (mat_c),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .busy_o     (busy)
  );

  function automatic cmat_t mm(input logic [15:0][7:0] a,
                               input logic [15:0][7:0] b);
    cmat_t c;
    logic [31:0] s;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s = s + 32'(a[4*i+k]) * 32'(b[4*k+j]);
        c[4*i+j] = s[15:0];
      end
    return c;
  endfunction

  cmat_t p0 = '0;
  cmat_t p1 = '0;
  cmat_t p2 = '0;

  always @(posedge clk) begin
    p0 <= mm(mat_a, mat_b);
    p1 <= p0;
    p2 <= p1;
  end

  assign mat_c = p2;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = w;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 8; i++) push(ops[i]);
  endtask

  task automatic model();
    cmat_t c;
    c = mm({ops[3], ops[2], ops[1], ops[0]},
           {ops[7], ops[6], ops[5], ops[4]});
    for (int w = 0; w < 8; w++)
      expq.push_back({c[2*w+1], c[2*w]});
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_A"}, mat_a, 0);
    chk({tag, "_B"}, mat_b, 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input bit bp, input bit strict);
    int got;
    int k;
    bit stalled;
    logic [31:0] pd;
    logic pl;
    logic [31:0] e;
    got = 0;
    k = 0;
    stalled = 0;
    pd = '0;
    pl = 1'b0;
    while (got < n && k < 300) begin
      if (bp)
        out_ready = (k % 4 == 0 || k % 4 == 3) ? 1'b1
                  : 1'($urandom_range(0, 3) == 0);
      else
        out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (stalled) begin
          chk("hold_data", out_data, pd);
          chk("hold_last", out_last, pl);
        end
        if (out_ready) begin
          e = expq.pop_front();
          chk("out_data", out_data, e);
          chk("out_last", out_last, (got % 8) == 7);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = out_data;
          pl = out_last;
        end
      end else if (strict) begin
        chk("valid_gap", out_valid, 1);
      end
      k++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    if (got < n) chk("drain_timeout", got, n);
  endtask

  initial begin
    // reset state
    #12;
    check_idle("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    @(posedge clk); #1;

    // identity + latency
    ops = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000,
            32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    load_ops();
    chk("id_A", mat_a, {ops[3], ops[2], ops[1], ops[0]});
    chk("id_B", mat_b, {ops[7], ops[6], ops[5], ops[4]});
    chk("id_busy", busy, 1);
    repeat (4) begin
      @(negedge clk);
      chk("lat_rdy", in_ready, 0);
      chk("lat_vld", out_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("cap_rdy", in_ready, 1);
    chk("cap_vld", out_valid, 1);
    chk("hold_A", mat_a, {ops[3], ops[2], ops[1], ops[0]});
    @(posedge clk); #1;
    expq = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007,
             32'h000A0009, 32'h000C000B, 32'h000E000D, 32'h0010000F};
    drain(8, 0, 1);
    @(negedge clk);
    chk("id_done_vld", out_valid, 0);
    chk("id_done_busy", busy, 0);
    @(posedge clk); #1;

    // backpressure
    ops = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D,
            32'h01010101, 32'h02020202, 32'h00000003, 32'h11223344};
    load_ops();
    model();
    drain(8, 1, 0);
    @(negedge clk);
    chk("bp_extra", out_valid, 0);
    @(posedge clk); #1;

    // overlap: pair 2 waits in hold until pair 1's last word leaves
    ops = '{32'h10203040, 32'h05060708, 32'h7F7F7F7F, 32'h00FF00FF,
            32'h01020304, 32'h0A0B0C0D, 32'hFF000001, 32'h80808080};
    load_ops();
    model();
    wait_cycles(LAT + 3);
    chk("ov_p1_vld", out_valid, 1);
    ops = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h55AA55AA,
            32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13579BDF, 32'h02468ACE};
    load_ops();
    model();
    wait_cycles(LAT + 3);
    @(negedge clk);
    chk("ov_hold_rdy", in_ready, 0);
    chk("ov_busy", busy, 1);
    @(posedge clk); #1;
    drain(16, 0, 1);
    @(negedge clk);
    chk("ov_done_vld", out_valid, 0);
    chk("ov_done_rdy", in_ready, 1);
    @(posedge clk); #1;

    // saturation
    for (int i = 0; i < 8; i++) ops[i] = 32'hFFFFFFFF;
    load_ops();
    repeat (8) expq.push_back(32'hF804F804);
    drain(8, 0, 0);

    // reset after input word 5
    ops = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    for (int i = 0; i < 6; i++) push(ops[i]);
    rst_n = 1'b0;
    #1;
    check_idle("rst_load");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ops = '{32'h01000201, 32'h00030004, 32'h05000006, 32'h00070800,
            32'h09000A00, 32'h000B000C, 32'h0D0E0F10, 32'h01010101};
    load_ops();
    model();
    drain(8, 0, 0);

    // reset after output word 3
    ops = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3,
            32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F00};
    load_ops();
    model();
    drain(3, 0, 0);
    expq.delete();
    rst_n = 1'b0;
    #1;
    check_idle("rst_drain");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_replay", out_valid, 0);
    @(posedge clk); #1;
    ops = '{32'h00000002, 32'h00000200, 32'h00020000, 32'h02000000,
            32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    load_ops();
    model();
    drain(8, 0, 0);
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
